// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan multiplexer:
// active-low segment patterns {g,f,e,d,c,b,a}, slot state and hex decode.
package ssd_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } slot_state_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_scan_mux_hex_decoder.sv
// Combinational hex digit to active-low seven-segment pattern.
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    // pure lookup, no state
    always_comb begin
        o_seg = hex_to_seg(i_hex);
    end

endmodule

// File: rtl/ssd_scan_mux.sv
// Four-digit common-anode display scanner with per-frame digit snapshot,
// per-slot blanking gap and registered active-low outputs.
// Optional: define SSD_LEADING_ZERO_BLANK_EN to suppress leading zeros
// (digits 4..2) at snapshot time.
module ssd_scan_mux
    import ssd_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       i_CLK,
    input  logic       i_RESET_N,
    input  logic [3:0] i_Digit_1_val,
    input  logic [3:0] i_Digit_2_val,
    input  logic [3:0] i_Digit_3_val,
    input  logic [3:0] i_Digit_4_val,
    input  logic [3:0] i_Digit_EN,
    input  logic [3:0] i_DP,
    output logic [3:0] o_AN,
    output logic [6:0] o_SEG,
    output logic       o_DP,
    output logic       o_FRAME
);

    localparam int unsigned  CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam slot_state_e  RST_STATE = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    slot_state_e     state_q, state_d;
    logic [3:0][3:0] dig_q, dig_d;
    logic [3:0]      en_q, en_d;
    logic [3:0]      dpm_q, dpm_d;
    logic            frame_q, frame_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;

    logic            snap;
    logic [3:0]      supp;
    logic [3:0]      cur_digit;
    logic [6:0]      cur_seg;

    // registers: slot timing, slot state, snapshot and outputs
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= RST_STATE;
            dig_q   <= '0;
            en_q    <= '0;
            dpm_q   <= '0;
            frame_q <= 1'b0;
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            dig_q   <= dig_d;
            en_q    <= en_d;
            dpm_q   <= dpm_d;
            frame_q <= frame_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    // slot counter, next slot state and frame snapshot capture
    always_comb begin
        snap = (cnt_q == '0) && (idx_q == 2'd0);

`ifdef SSD_LEADING_ZERO_BLANK_EN
        supp[3] = (i_Digit_4_val == 4'd0);
        supp[2] = (i_Digit_4_val == 4'd0) && (i_Digit_3_val == 4'd0);
        supp[1] = (i_Digit_4_val == 4'd0) && (i_Digit_3_val == 4'd0) &&
                  (i_Digit_2_val == 4'd0);
        supp[0] = 1'b0;
`else
        supp = '0;
`endif

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
            idx_d = idx_q;
        end

        state_d = (cnt_d < BLANK_END) ? BLANK : DRIVE;

        dig_d = dig_q;
        en_d  = en_q;
        dpm_d = dpm_q;
        if (snap) begin
            dig_d = {i_Digit_4_val, i_Digit_3_val, i_Digit_2_val, i_Digit_1_val};
            en_d  = i_Digit_EN & ~supp;
            dpm_d = i_DP;
        end
    end

    // outputs for the current slot use the snapshot as it will be after this
    // edge, so the first slot of a frame already shows the fresh capture
    always_comb begin
        cur_digit = dig_d[idx_q];
        frame_d   = snap;
        an_d      = '1;
        seg_d     = SEG_BLANK;
        dp_d      = 1'b1;
        if ((state_q == DRIVE) && en_d[idx_q]) begin
            an_d[idx_q] = 1'b0;
            seg_d       = cur_seg;
            dp_d        = ~dpm_d[idx_q];
        end
    end

    ssd_hex_decoder u_dec (
        .i_hex (cur_digit),
        .o_seg (cur_seg)
    );

    assign o_AN    = an_q;
    assign o_SEG   = seg_q;
    assign o_DP    = dp_q;
    assign o_FRAME = frame_q;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Directed bench for ssd_scan_mux: scan order, blanking, snapshot coherence,
// enables/DP, async reset, leading-zero option and a minimal-divider instance.
module tb_ssd_scan_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rst_b_n;
    logic [3:0] d1, d2, d3, d4, en, dp;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dpo, frame;

    logic [3:0] b1, b2, b3, b4, bdp;
    logic [3:0] an_b;
    logic [6:0] seg_b;
    logic       dpo_b, frame_b;

    int total = 0;
    int bad   = 0;

    ssd_scan_mux #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) u_dut (
        .i_CLK         (clk),
        .i_RESET_N     (rst_n),
        .i_Digit_1_val (d1),
        .i_Digit_2_val (d2),
        .i_Digit_3_val (d3),
        .i_Digit_4_val (d4),
        .i_Digit_EN    (en),
        .i_DP          (dp),
        .o_AN          (an),
        .o_SEG         (seg),
        .o_DP          (dpo),
        .o_FRAME       (frame)
    );

    ssd_scan_mux #(.REFRESH_DIV(2), .BLANK_CYCLES(0)) u_dut_min (
        .i_CLK         (clk),
        .i_RESET_N     (rst_b_n),
        .i_Digit_1_val (b1),
        .i_Digit_2_val (b2),
        .i_Digit_3_val (b3),
        .i_Digit_4_val (b4),
        .i_Digit_EN    (4'b1111),
        .i_DP          (bdp),
        .o_AN          (an_b),
        .o_SEG         (seg_b),
        .o_DP          (dpo_b),
        .o_FRAME       (frame_b)
    );

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Checks edges first..last (edge 1 = first edge after reset release) of
    // the 8/2 instance; sN is the expected pattern of the digit on AN[N].
    task automatic scan(input int first, input int last,
                        input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3,
                        input logic [3:0] en_m, input logic [3:0] dp_m);
        logic [6:0] segt [4];
        logic [3:0] ant  [4];
        segt[0] = s0; segt[1] = s1; segt[2] = s2; segt[3] = s3;
        ant[0] = 4'b1110; ant[1] = 4'b1101; ant[2] = 4'b1011; ant[3] = 4'b0111;
        for (int e = first; e <= last; e++) begin
            int   c;
            int   s;
            logic drv;
            @(posedge clk);
            #1;
            c   = (e - 1) % 8;
            s   = ((e - 1) / 8) % 4;
            drv = (c >= 2) && en_m[s];
            chk($sformatf("an e=%0d", e), {3'b0, an}, {3'b0, drv ? ant[s] : 4'b1111});
            chk($sformatf("seg e=%0d", e), seg, drv ? segt[s] : 7'b1111111);
            chk($sformatf("dp e=%0d", e), {6'b0, dpo}, {6'b0, !(drv && dp_m[s])});
            chk($sformatf("frame e=%0d", e), {6'b0, frame}, {6'b0, ((e - 1) % 32) == 0});
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        rst_b_n = 1'b0;
        d1 = 4'd4; d2 = 4'd3; d3 = 4'd2; d4 = 4'd1;
        en = 4'b1111; dp = 4'b0000;
        b1 = '0; b2 = '0; b3 = '0; b4 = '0; bdp = '0;

        repeat (3) @(negedge clk);
        chk("rst_an", {3'b0, an}, {3'b0, 4'b1111});
        chk("rst_seg", seg, 7'b1111111);
        chk("rst_dp", {6'b0, dpo}, 7'd1);
        chk("rst_frame", {6'b0, frame}, 7'd0);
        rst_n = 1'b1;

        // basic scan of {4,3,2,1}={1,2,3,4}, two frames
        scan(1, 64, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 4'b1111, 4'b0000);

        // digit 1 changes mid-frame (idx 2, cnt 3) - slot 0 keeps 4 until next frame
        scan(65, 83, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 4'b1111, 4'b0000);
        d1 = 4'd9;
        scan(84, 96, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 4'b1111, 4'b0000);
        scan(97, 160, 7'b0010000, 7'b0110000, 7'b0100100, 7'b1111001, 4'b1111, 4'b0000);

        // enables 0101 with DP on digit 3 only
        en = 4'b0101; dp = 4'b0100;
        scan(161, 245, 7'b0010000, 7'b0110000, 7'b0100100, 7'b1111001, 4'b0101, 4'b0100);

        // edge 245 is mid-DRIVE of slot 2: reset must clear outputs without a clock
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", {3'b0, an}, {3'b0, 4'b1111});
        chk("async_rst_seg", seg, 7'b1111111);
        chk("async_rst_dp", {6'b0, dpo}, 7'd1);
        chk("async_rst_frame", {6'b0, frame}, 7'd0);

        d1 = 4'd7; d2 = 4'd8; d3 = 4'hA; d4 = 4'hF;
        en = 4'b1111; dp = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        scan(1, 32, 7'b1111000, 7'b0000000, 7'b0001000, 7'b0001110, 4'b1111, 4'b0000);

        // leading zeros {4,3,2,1}={0,0,5,0} with all DPs requested
        d1 = 4'd0; d2 = 4'd5; d3 = 4'd0; d4 = 4'd0;
        dp = 4'b1111;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        scan(33, 64, 7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000, 4'b0011, 4'b0011);
`else
        scan(33, 64, 7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000, 4'b1111, 4'b1111);
`endif

        // minimal divider, no blanking: exactly one anode low every cycle
        @(negedge clk);
        rst_b_n = 1'b1;
        for (int i = 1; i <= 1000; i++) begin
            int zeros;
            b1  = 4'($urandom_range(15));
            b2  = 4'($urandom_range(15));
            b3  = 4'($urandom_range(15));
            b4  = 4'($urandom_range(15));
            bdp = 4'($urandom_range(15));
            @(posedge clk);
            #1;
            zeros = 0;
            for (int k = 0; k < 4; k++) begin
                if (an_b[k] == 1'b0) zeros++;
            end
            chk($sformatf("min_an_zeros i=%0d", i), 7'(zeros), 7'd1);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard time limit so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
